// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch / IF-ID slice of the LEGv8 pipeline.
//   addr_t  : 64-bit program counter / byte address
//   instr_t : 32-bit instruction word
//   ifid_t  : contents of the IF/ID pipeline register (pc, instr, valid)
//   NOP_INSTR : encoding loaded into IF/ID whenever a bubble is inserted
//   PC_INC    : sequential fetch stride in bytes
package cpu_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam instr_t NOP_INSTR = 32'hD503201F;
    localparam addr_t  PC_INC    = 64'd4;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
        logic   valid;
    } ifid_t;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Bundle of every non-clock/reset signal of the fetch stage.
//   Hazard-unit controls : pc_write, ifid_write, if_flush, br_taken, br_target
//   Instruction memory   : imem_addr (out of the stage), imem_rdata, imem_valid
//   IF/ID register       : ifid_pc, ifid_instr, ifid_valid
//   Debug counters       : stall_cnt, flush_cnt
// The slave modport is the fetch stage itself; master is its environment.
interface fetch_ifid_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);

    logic               pc_write;
    logic               ifid_write;
    logic               if_flush;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic               ifid_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output pc_write, ifid_write, if_flush, br_taken, br_target,
        output imem_rdata, imem_valid,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_write, ifid_write, if_flush, br_taken, br_target,
        input  imem_rdata, imem_valid,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_ifid_stage_sat_counter.sv
// Saturating up-counter used for the stall / flush performance counters.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Advance only while below the all-ones ceiling so the value never wraps.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage of the 5-stage LEGv8 pipeline: owns the PC, drives the
// instruction-memory address and holds the IF/ID pipeline register.
// Consumes the hazard unit's stall / flush / redirect controls.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of fetch_ifid_stage_if (controls, imem, IF/ID, counters)
// All IF/ID fields and both counters come straight from registers.
module fetch_ifid_stage #(
    parameter int          ADDR_W    = 64,
    parameter int          INSTR_W   = 32,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    fetch_ifid_stage_if.slave bus
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    ifid_t             ifid_q;
    ifid_t             ifid_d;
    logic              stall_event;
    logic              flush_event;

    // The fetch address is the PC itself, no extra register stage.
    assign bus.imem_addr = pc_q;

    // PC next state: a resolved taken branch beats a load-use stall, and a
    // memory wait also freezes the PC so the same address is retried.
    // The +4 wraps silently at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (bus.br_taken) begin
            pc_d = bus.br_target;
        end else if (bus.pc_write && bus.imem_valid) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    // IF/ID next state: a flush squashes even while IF/ID is held, and a
    // missing memory response becomes a bubble rather than stale data.
    // Bubbles still record the PC they replaced, which helps debug traces.
    always_comb begin
        ifid_d = ifid_q;
        if (bus.if_flush || (bus.ifid_write && !bus.imem_valid)) begin
            ifid_d.pc    = addr_t'(pc_q);
            ifid_d.instr = instr_t'(NOP_INSTR);
            ifid_d.valid = 1'b0;
        end else if (bus.ifid_write) begin
            ifid_d.pc    = addr_t'(pc_q);
            ifid_d.instr = instr_t'(bus.imem_rdata);
            ifid_d.valid = 1'b1;
        end
    end

    // PC and IF/ID registers; reset wins over every control input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= ADDR_W'(RESET_PC);
            ifid_q.pc    <= '0;
            ifid_q.instr <= instr_t'(NOP_INSTR);
            ifid_q.valid <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.ifid_pc    = ADDR_W'(ifid_q.pc);
    assign bus.ifid_instr = INSTR_W'(ifid_q.instr);
    assign bus.ifid_valid = ifid_q.valid;

    // A cycle is a stall if either write enable is low; stall and flush are
    // counted independently so one cycle can bump both.
    assign stall_event = !bus.pc_write || !bus.ifid_write;
    assign flush_event = bus.if_flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_event),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_event),
        .count (bus.flush_cnt)
    );

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage. Two copies of the stage share
// identical stimulus: one with 16-bit counters, one with 2-bit counters so
// counter saturation is reached quickly.
module tb_fetch_ifid_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        flush;
        logic        br;
        logic [63:0] tgt;
        logic        iv;
        logic [31:0] rd;
        logic [63:0] e_pc;
        logic [63:0] e_ipc;
        logic [31:0] e_ins;
        logic        e_v;
        int          e_stall;
        int          e_flush;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    int compared   = 0;
    int mismatched = 0;

    // Reference state of the fetch stage, kept as plain numbers.
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_ins;
    logic        m_v;
    int          m_stall;
    int          m_flush;

    vec_t vecs[18];

    fetch_ifid_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(16)) bus ();
    fetch_ifid_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(2))  bus_s ();

    // Both copies see exactly the same inputs.
    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.if_flush     = if_flush;
    assign bus.br_taken     = br_taken;
    assign bus.br_target    = br_target;
    assign bus.imem_rdata   = imem_rdata;
    assign bus.imem_valid   = imem_valid;
    assign bus_s.pc_write   = pc_write;
    assign bus_s.ifid_write = ifid_write;
    assign bus_s.if_flush   = if_flush;
    assign bus_s.br_taken   = br_taken;
    assign bus_s.br_target  = br_target;
    assign bus_s.imem_rdata = imem_rdata;
    assign bus_s.imem_valid = imem_valid;

    fetch_ifid_stage #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_ifid_stage #(.CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    function automatic int satAdd(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic vec_t mk(input logic rst, input logic pcw, input logic ifw,
                                input logic flush, input logic br, input logic [63:0] tgt,
                                input logic iv, input logic [31:0] rd,
                                input logic [63:0] e_pc, input logic [63:0] e_ipc,
                                input logic [31:0] e_ins, input logic e_v,
                                input int e_stall, input int e_flush);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.flush = flush; v.br = br;
        v.tgt = tgt; v.iv = iv; v.rd = rd;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_ins = e_ins; v.e_v = e_v;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic cmp(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got %h, required %h", tag, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pcw, input logic ifw,
                                 input logic flush, input logic br, input logic [63:0] tgt,
                                 input logic iv, input logic [31:0] rd);
        reset      = rst;
        pc_write   = pcw;
        ifid_write = ifw;
        if_flush   = flush;
        br_taken   = br;
        br_target  = tgt;
        imem_valid = iv;
        imem_rdata = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] e_pc,
                               input logic [63:0] e_ipc, input logic [31:0] e_ins,
                               input logic e_v, input int e_stall, input int e_flush);
        int s_stall;
        int s_flush;
        s_stall = (e_stall > 3) ? 3 : e_stall;
        s_flush = (e_flush > 3) ? 3 : e_flush;
        cmp(tag, "imem_addr",   bus.imem_addr,            e_pc);
        cmp(tag, "ifid_pc",     bus.ifid_pc,              e_ipc);
        cmp(tag, "ifid_instr",  64'(bus.ifid_instr),      64'(e_ins));
        cmp(tag, "ifid_valid",  64'(bus.ifid_valid),      64'(e_v));
        cmp(tag, "stall_cnt",   64'(bus.stall_cnt),       64'(e_stall));
        cmp(tag, "flush_cnt",   64'(bus.flush_cnt),       64'(e_flush));
        cmp(tag, "imem_addr2",  bus_s.imem_addr,          e_pc);
        cmp(tag, "stall_cnt2",  64'(bus_s.stall_cnt),     64'(s_stall));
        cmp(tag, "flush_cnt2",  64'(bus_s.flush_cnt),     64'(s_flush));
    endtask

    // Reference model: next state computed directly from the fetch rules,
    // using the inputs currently applied.
    task automatic modelStep();
        logic [63:0] n_pc;
        if (reset) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_ins = NOP; m_v = 1'b0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (br_taken)                     n_pc = br_target;
            else if (pc_write && imem_valid)  n_pc = m_pc + 64'd4;
            else                              n_pc = m_pc;
            if (if_flush) begin
                m_ipc = m_pc; m_ins = NOP; m_v = 1'b0;
            end else if (ifid_write) begin
                m_ipc = m_pc;
                m_ins = imem_valid ? imem_rdata : NOP;
                m_v   = imem_valid;
            end
            if (!pc_write || !ifid_write) m_stall = satAdd(m_stall, 65535);
            if (if_flush)                 m_flush = satAdd(m_flush, 65535);
            m_pc = n_pc;
        end
    endtask

    initial begin
        string tag;
        logic [63:0] tgt;

        $display("[TB] fetch_ifid_stage bench start");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);

        // Directed sequence: rst pcw ifw flush br tgt iv rd | pc ifid_pc instr valid stall flush
        vecs[0]  = mk(1,1,1,0,0,64'h0,  1,32'h0,        64'h0,   64'h0,   NOP,          0,0,0);
        vecs[1]  = mk(0,1,1,0,0,64'h0,  1,32'hAAAA0001, 64'h4,   64'h0,   32'hAAAA0001, 1,0,0);
        vecs[2]  = mk(0,1,1,0,0,64'h0,  1,32'hBBBB0002, 64'h8,   64'h4,   32'hBBBB0002, 1,0,0);
        vecs[3]  = mk(0,0,0,0,0,64'h0,  1,32'hCCCC0003, 64'h8,   64'h4,   32'hBBBB0002, 1,1,0);
        vecs[4]  = mk(0,0,0,0,0,64'h0,  1,32'hCCCC0003, 64'h8,   64'h4,   32'hBBBB0002, 1,2,0);
        vecs[5]  = mk(0,1,1,0,0,64'h0,  1,32'hCCCC0003, 64'hC,   64'h8,   32'hCCCC0003, 1,2,0);
        vecs[6]  = mk(0,1,1,1,1,64'h100,1,32'hDDDD0004, 64'h100, 64'hC,   NOP,          0,2,1);
        vecs[7]  = mk(0,1,1,0,0,64'h0,  1,32'hEEEE0005, 64'h104, 64'h100, 32'hEEEE0005, 1,2,1);
        vecs[8]  = mk(0,0,0,1,1,64'h20, 1,32'hFFFF0006, 64'h20,  64'h104, NOP,          0,3,2);
        vecs[9]  = mk(0,1,1,0,0,64'h0,  0,32'h12340007, 64'h20,  64'h20,  NOP,          0,3,2);
        vecs[10] = mk(0,1,1,0,0,64'h0,  1,32'h12340008, 64'h24,  64'h20,  32'h12340008, 1,3,2);
        vecs[11] = mk(0,1,1,0,1,64'hFFFF_FFFF_FFFF_FFFC,1,32'h12340009,
                      64'hFFFF_FFFF_FFFF_FFFC, 64'h24, 32'h12340009, 1,3,2);
        vecs[12] = mk(0,1,1,0,0,64'h0,  1,32'h1234000A, 64'h0,
                      64'hFFFF_FFFF_FFFF_FFFC, 32'h1234000A, 1,3,2);
        vecs[13] = mk(0,0,1,0,0,64'h0,  1,32'h1234000B, 64'h0,   64'h0,   32'h1234000B, 1,4,2);
        vecs[14] = mk(0,1,0,0,0,64'h0,  1,32'h1234000C, 64'h4,   64'h0,   32'h1234000B, 1,5,2);
        vecs[15] = mk(0,0,0,1,0,64'h0,  1,32'h1234000D, 64'h4,   64'h4,   NOP,          0,6,3);
        vecs[16] = mk(1,0,0,1,1,64'h300,1,32'h1234000E, 64'h0,   64'h0,   NOP,          0,0,0);
        vecs[17] = mk(0,1,1,0,0,64'h0,  1,32'h1234000F, 64'h4,   64'h0,   32'h1234000F, 1,0,0);

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].flush,
                          vecs[i].br, vecs[i].tgt, vecs[i].iv, vecs[i].rd);
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            checkOutput(tag, vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_ins, vecs[i].e_v,
                        vecs[i].e_stall, vecs[i].e_flush);
        end

        // Randomized phase against the reference model, starting from reset.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("rnd_reset", m_pc, m_ipc, m_ins, m_v, m_stall, m_flush);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            else
                tgt = {$urandom(), $urandom()} & ~64'h3;
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) == 0,
                          tgt,
                          $urandom_range(0, 5) != 0,
                          $urandom());
            modelStep();
            @(posedge clk);
            #1;
            tag = $sformatf("rnd%0d", i);
            checkOutput(tag, m_pc, m_ipc, m_ins, m_v, m_stall, m_flush);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Fetch-side consumer of the hazard unit's stall/flush outputs in the 5-stage LEGv8 pipeline.
- Owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register.
- Implements hold on load-use stall, bubble insertion on branch flush, and PC redirect on taken branch.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
ADDR_W, 64, PC/address width
INSTR_W, 32, instruction width
RESET_PC, 64'h0, PC value after reset
NOP_INSTR, 32'hD503201F, encoding loaded into IF/ID on a bubble
CNT_W, 16, width of the event counters

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
pc_write  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
ifid_write  input  1  1 = IF/ID may load; 0 = hold IF/ID
if_flush  input  1  1 = squash the instruction entering IF/ID
br_taken  input  1  taken branch resolved; redirect PC to br_target
br_target  input  ADDR_W  branch target address
imem_addr  output  ADDR_W  fetch address, equal to the current PC
imem_rdata  input  INSTR_W  instruction at imem_addr
imem_valid  input  1  imem_rdata is valid this cycle
ifid_pc  output  ADDR_W  PC of the instruction held in IF/ID
ifid_instr  output  INSTR_W  instruction held in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction, not a bubble
stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0 or ifid_write=0
flush_cnt  output  CNT_W  saturating count of cycles with if_flush=1

Behaviour:
- Reset (synchronous, has priority over every other input):
  - PC=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, stall_cnt=0, flush_cnt=0.
- imem_addr is driven combinationally from the PC register; zero added latency.
- PC next-state, highest priority first:
  1. br_taken=1: PC<=br_target. Applies even when pc_write=0; redirect overrides stall.
  2. pc_write=0: PC holds.
  3. imem_valid=0: PC holds (memory wait).
  4. Otherwise PC<=PC+4, wrapping modulo 2^ADDR_W with no error flag.
- IF/ID next-state, highest priority first:
  1. if_flush=1: load bubble (ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=PC). Overrides ifid_write=0.
  2. ifid_write=0: hold all three fields.
  3. imem_valid=0: load bubble.
  4. Otherwise ifid_pc<=PC, ifid_instr<=imem_rdata, ifid_valid<=1.
- A redirected PC takes effect the cycle after br_taken. The first target instruction appears in IF/ID two cycles after br_taken.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1; no wrap.
  - In a cycle that is both stalled and flushed, both counters increment.
- Reset asserted mid-stall or mid-flush discards all pending state; the first fetch after reset deasserts is at RESET_PC.
- No combinational path from any input to ifid_* outputs or counters; all are registered.

Decomposition:
- Shared package cpu_pkg holds:
  - addr_t (logic [63:0]) and instr_t (logic [31:0]);
  - constants NOP_INSTR and PC_INC=4;
  - struct ifid_t {pc, instr, valid}.
- One sub-module: sat_counter (CNT_W param; inc, reset, count), instantiated twice.

Test Plan:
- Reset then 3 cycles with imem_valid=1, rdata=A,B,C, all enables 1 -> imem_addr 0,4,8; IF/ID shows (0,A,1), (4,B,1), (8,C,1).
- pc_write=0 and ifid_write=0 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds (4,B,1), stall_cnt=2, then resumes at 8.
- br_taken=1, br_target=0x100, if_flush=1 at PC=12 -> next cycle PC=0x100, IF/ID bubble (NOP, valid=0), flush_cnt=1; following cycle IF/ID=(0x100, rdata, 1).
- br_taken=1 with pc_write=0 simultaneously -> PC=br_target (redirect wins); if_flush=1 with ifid_write=0 -> bubble loaded.
- imem_valid=0 for 1 cycle at PC=0x20 -> PC holds 0x20, IF/ID bubble; PC=2^64-4 advances to 0.
- CNT_W=2, 5 stall cycles -> stall_cnt=3 (saturated); reset asserted mid-stall -> all outputs at reset values next cycle.
